// File: rtl/definitions.sv
// Shared core definitions: register/instruction types, opcode/funct encodings,
// and the hazard-controller forwarding and shadow-stage types.
`default_nettype none

package definitions;

  typedef logic [4:0]  Register;
  typedef logic [31:0] Instruction;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } Opcode;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2a
  } Funct;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } FwdSel;

  // rs/rt hold 0 when the operand is not read, so r0 doubles as "no read".
  typedef struct packed {
    logic    valid;
    Register rs;
    Register rt;
    Register dest;
    logic    writes;
    logic    is_load;
    logic    is_mem;
  } StageTag;

  localparam StageTag TAG_BUBBLE = '0;

  function automatic logic reg_match(input Register a, input Register b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic FwdSel fwd_sel(input Register src, input StageTag m, input StageTag w);
    if (m.valid && m.writes && !m.is_load && reg_match(m.dest, src)) return FWD_MEM;
    if (w.valid && w.writes && reg_match(w.dest, src))               return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_use.sv
// Combinational register-use decoder: which source registers an instruction
// reads, which register it writes, and whether it is a load / memory access.
`default_nettype none

import definitions::*;

module reg_use (
  input  logic [31:0] instr_i,
  output logic        rs_used_o,
  output logic        rt_used_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  dest_o,
  output logic        writes_o,
  output logic        is_load_o,
  output logic        is_mem_o
);

  logic [4:0] dest_raw;
  logic       unused_lo;

  assign rs_o      = instr_i[25:21];
  assign rt_o      = instr_i[20:16];
  assign unused_lo = ^instr_i[10:0];

  always_comb begin
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    dest_raw  = 5'd0;
    is_load_o = 1'b0;
    is_mem_o  = 1'b0;
    case (instr_i[31:26])
      OP_RTYPE: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
        dest_raw  = instr_i[15:11];
      end
      OP_LW: begin
        rs_used_o = 1'b1;
        dest_raw  = instr_i[20:16];
        is_load_o = 1'b1;
        is_mem_o  = 1'b1;
      end
      OP_SW: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
        is_mem_o  = 1'b1;
      end
      OP_BEQ: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
      end
      default: ;
    endcase
  end

  // A write to r0 is architecturally discarded, so it never counts as a write.
  assign dest_o   = dest_raw;
  assign writes_o = (dest_raw != 5'd0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall/flush/forwarding from the
// decode instruction and a shadow copy of EX/MEM/WB, plus a stall-cycle counter.
`default_nettype none

import definitions::*;

module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             branch_taken_d,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             stall_all,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       dec_rs_used, dec_rt_used, dec_writes, dec_is_load, dec_is_mem;
  logic [4:0] dec_rs, dec_rt, dec_dest;

  StageTag d_tag;
  StageTag e_q, m_q, w_q;
  StageTag e_d, m_d, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic d_is_beq, d_is_j;
  logic reads_e, reads_m;
  logic load_use, br_stall, mem_wait, hazard;

  reg_use u_reg_use (
    .instr_i   (instr_d),
    .rs_used_o (dec_rs_used),
    .rt_used_o (dec_rt_used),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .dest_o    (dec_dest),
    .writes_o  (dec_writes),
    .is_load_o (dec_is_load),
    .is_mem_o  (dec_is_mem)
  );

  always_comb begin
    d_tag = TAG_BUBBLE;
    if (valid_d) begin
      d_tag.valid   = 1'b1;
      d_tag.rs      = dec_rs_used ? dec_rs : 5'd0;
      d_tag.rt      = dec_rt_used ? dec_rt : 5'd0;
      d_tag.dest    = dec_dest;
      d_tag.writes  = dec_writes;
      d_tag.is_load = dec_is_load;
      d_tag.is_mem  = dec_is_mem;
    end
  end

  assign d_is_beq = valid_d && (instr_d[31:26] == OP_BEQ);
  assign d_is_j   = valid_d && (instr_d[31:26] == OP_J);

  assign reads_e = reg_match(e_q.dest, d_tag.rs) || reg_match(e_q.dest, d_tag.rt);
  assign reads_m = reg_match(m_q.dest, d_tag.rs) || reg_match(m_q.dest, d_tag.rt);

  assign load_use = valid_d && e_q.valid && e_q.is_load && reads_e;
  assign br_stall = d_is_beq && ((e_q.valid && e_q.writes && reads_e) ||
                                 (m_q.valid && m_q.is_load && reads_m));
  assign mem_wait = m_q.valid && m_q.is_mem && !mem_ready;
  assign hazard   = load_use || br_stall;

  // Outputs are gated by reset so a flushing instruction in decode stays quiet
  // while the core is held in reset.
  assign stall_all = reset && mem_wait;
  assign stall_d   = reset && !mem_wait && hazard;
  assign stall_f   = stall_all || stall_d;
  assign flush_d   = reset && !mem_wait && !hazard &&
                     (d_is_j || (d_is_beq && branch_taken_d));

  assign fwd_a_e   = fwd_sel(e_q.valid ? e_q.rs : 5'd0, m_q, w_q);
  assign fwd_b_e   = fwd_sel(e_q.valid ? e_q.rt : 5'd0, m_q, w_q);
  assign stall_cnt = cnt_q;

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (stall_all) begin
      w_d = TAG_BUBBLE;
    end else begin
      e_d = stall_d ? TAG_BUBBLE : d_tag;
      m_d = e_q;
      w_d = m_q;
    end
    cnt_d = cnt_q;
    if (stall_f && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q   <= TAG_BUBBLE;
      m_q   <= TAG_BUBBLE;
      w_q   <= TAG_BUBBLE;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// outputs; a negedge monitor pops and compares a full-width and a 2-bit-counter instance.
`default_nettype none

module tb_pipe_hazard_ctrl;
  import definitions::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid_d, branch_taken_d, mem_ready;
  logic [31:0] instr_d;

  logic        stall_f, stall_d, flush_d, stall_all;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [31:0] stall_cnt;

  logic        s_stall_f, s_stall_d, s_flush_d, s_stall_all;
  logic [1:0]  s_fwd_a_e, s_fwd_b_e;
  logic [1:0]  s_stall_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .branch_taken_d(branch_taken_d), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .stall_all(stall_all),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .branch_taken_d(branch_taken_d), .mem_ready(mem_ready),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .stall_all(s_stall_all),
    .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    string       name;
    logic [7:0]  flags;
    logic [31:0] cnt;
    logic [1:0]  cnt_sat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_sum = 0;

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rt, input logic [4:0] rs);
    return {OP_LW, rs, rt, 16'h0004};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rt, input logic [4:0] rs);
    return {OP_SW, rs, rt, 16'h0008};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs, input logic [4:0] rt);
    return {OP_BEQ, rs, rt, 16'h0002};
  endfunction
  function automatic logic [31:0] enc_j();
    return {OP_J, 26'h2f01234};
  endfunction

  task automatic step(input string name, input logic [31:0] ins,
                      input bit v, input bit tk, input bit mr, input bit rn,
                      input bit sf, input bit sd, input bit fl, input bit sa,
                      input FwdSel fa, input FwdSel fb);
    exp_t e;
    @(posedge clk);
    #1;
    instr_d        = ins;
    valid_d        = v;
    branch_taken_d = tk;
    mem_ready      = mr;
    reset          = rn;
    if (!rn) exp_sum = 0;
    e.name    = name;
    e.flags   = {sf, sd, fl, sa, fa, fb};
    e.cnt     = exp_sum;
    e.cnt_sat = (exp_sum > 3) ? 2'd3 : 2'(exp_sum);
    q.push_back(e);
    if (rn && sf) exp_sum++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks += 4;
      if ({stall_f, stall_d, flush_d, stall_all, fwd_a_e, fwd_b_e} !== mon_e.flags) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b", mon_e.name,
                 {stall_f, stall_d, flush_d, stall_all, fwd_a_e, fwd_b_e}, mon_e.flags);
      end
      if (stall_cnt !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", mon_e.name, stall_cnt, mon_e.cnt);
      end
      if ({s_stall_f, s_stall_d, s_flush_d, s_stall_all, s_fwd_a_e, s_fwd_b_e} !== mon_e.flags) begin
        errors++;
        $display("FAIL %s ctrl_w2: got %b expected %b", mon_e.name,
                 {s_stall_f, s_stall_d, s_flush_d, s_stall_all, s_fwd_a_e, s_fwd_b_e}, mon_e.flags);
      end
      if (s_stall_cnt !== mon_e.cnt_sat) begin
        errors++;
        $display("FAIL %s stall_cnt_w2: got %0d expected %0d", mon_e.name, s_stall_cnt, mon_e.cnt_sat);
      end
    end
  end

  localparam FwdSel R = FWD_REG;
  localparam FwdSel M = FWD_MEM;
  localparam FwdSel W = FWD_WB;

  initial begin
    reset = 1'b0; valid_d = 1'b0; branch_taken_d = 1'b0; mem_ready = 1'b1; instr_d = 32'd0;

    //    name            instr              v  tk mr rn  sf sd fl sa  fa fb
    step("rst0",          enc_j(),           1, 0, 1, 0,  0, 0, 0, 0,  R, R);
    step("rst1",          enc_j(),           1, 0, 1, 0,  0, 0, 0, 0,  R, R);
    step("release",       32'd0,             0, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("lu_lw",         enc_lw(4, 9),      1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("lu_stall",      enc_add(3, 4, 1),  1, 0, 1, 1,  1, 1, 0, 0,  R, R);
    step("lu_resume",     enc_add(3, 4, 1),  1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("lu_fwd_wb",     32'd0,             0, 0, 1, 1,  0, 0, 0, 0,  W, R);
    step("alu_add5",      enc_add(5, 1, 2),  1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("alu_add6",      enc_add(6, 5, 5),  1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("alu_fwd_mem",   enc_add(5, 1, 2),  1, 0, 1, 1,  0, 0, 0, 0,  M, M);
    step("pri_add5b",     enc_add(5, 1, 2),  1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("pri_add7",      enc_add(7, 5, 0),  1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("pri_m_over_w",  32'd0,             0, 0, 1, 1,  0, 0, 0, 0,  M, R);
    step("br_add3",       enc_add(3, 1, 2),  1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("br_stall",      enc_beq(3, 0),     1, 0, 1, 1,  1, 1, 0, 0,  R, R);
    step("br_flush",      enc_beq(3, 0),     1, 1, 1, 1,  0, 0, 1, 0,  R, R);
    step("j_flush",       enc_j(),           1, 0, 1, 1,  0, 0, 1, 0,  W, R);
    step("idle",          32'd0,             0, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("br2_lw",        enc_lw(8, 1),      1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("br2_stall1",    enc_beq(8, 0),     1, 1, 1, 1,  1, 1, 0, 0,  R, R);
    step("br2_stall2",    enc_beq(8, 0),     1, 1, 1, 1,  1, 1, 0, 0,  R, R);
    step("br2_flush",     enc_beq(8, 0),     1, 1, 1, 1,  0, 0, 1, 0,  R, R);
    step("mw_sw",         enc_sw(2, 8),      1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("mw_lw",         enc_lw(9, 1),      1, 0, 0, 1,  0, 0, 0, 0,  R, R);
    step("mw_wait1",      enc_add(11, 9, 9), 1, 0, 0, 1,  1, 0, 0, 1,  R, R);
    step("mw_wait2",      enc_add(11, 9, 9), 1, 0, 0, 1,  1, 0, 0, 1,  R, R);
    step("mw_wait3_j",    enc_j(),           1, 0, 0, 1,  1, 0, 0, 1,  R, R);
    step("mw_lu_after",   enc_add(11, 9, 9), 1, 0, 1, 1,  1, 1, 0, 0,  R, R);
    step("mw_resume",     enc_add(11, 9, 9), 1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("mw_fwd_wb",     32'd0,             0, 0, 1, 1,  0, 0, 0, 0,  W, W);
    step("rr_lw",         enc_lw(4, 1),      1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("rr_stall",      enc_beq(4, 0),     1, 0, 1, 1,  1, 1, 0, 0,  R, R);
    step("rr_reset",      enc_beq(4, 0),     1, 0, 1, 0,  0, 0, 0, 0,  R, R);
    step("rr_release",    enc_beq(4, 0),     1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("sat_sw",        enc_sw(1, 2),      1, 0, 1, 1,  0, 0, 0, 0,  R, R);
    step("sat_adv",       32'd0,             0, 0, 0, 1,  0, 0, 0, 0,  R, R);
    for (int i = 0; i < 5; i++)
      step("sat_wait",    32'd0,             0, 0, 0, 1,  1, 0, 0, 1,  R, R);
    step("sat_done",      32'd0,             0, 0, 1, 1,  0, 0, 0, 0,  R, R);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core: watches the instruction in decode and a shadow record of the instructions in EX/MEM/WB. Generates stall, flush and operand-forwarding controls around the decode/register-file stage. Sits beside the decode stage; all pipeline registers take their enables and flushes from this block. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk  in  1`: core clock; all state updates on its rising edge.
- `reset  in  1`: asynchronous, active-low reset (asserted at 0).
- `instr_d  in  Instruction (32)`: instruction currently in decode.
- `valid_d  in  1`: `instr_d` is a real instruction, not a bubble.
- `branch_taken_d  in  1`: decode-stage BEQ compare result, meaningful only when `instr_d` is BEQ.
- `mem_ready  in  1`: data memory completes the MEM-stage access this cycle.
- `stall_f  out  1`: hold the PC and the F/D register.
- `stall_d  out  1`: hold the D/E input; insert a bubble into EX.
- `flush_d  out  1`: replace the F/D register contents with a bubble.
- `stall_all  out  1`: freeze F, D, E and M. WB receives a bubble.
- `fwd_a_e  out  FwdSel (2)`: EX operand A source.
- `fwd_b_e  out  FwdSel (2)`: EX operand B source.
- `stall_cnt  out  CNT_W`: number of cycles in which `stall_f` was high, saturating.

## Operation
- **Per-instruction register use** (opcode/funct from the package):
  - RTYPE reads rs and rt, and writes rd.
  - LW reads rs and writes rt (load).
  - SW reads rs and rt, and writes nothing.
  - BEQ reads rs and rt.
  - J and all other opcodes read nothing and write nothing.
  - A write to register 0 is treated as no write. A read of register 0 never matches.
- **Shadow pipeline:** three entries E, M and W. Each entry holds {valid, rs, rt, dest, writes, is_load}.
  - Normal cycle: E←decode(instr_d, valid_d), M←E, W←M.
  - `stall_d` cycle: E←bubble (valid=0); M and W advance.
  - `stall_all` cycle: E and M hold; W←bubble.
- **Load-use stall:** `stall_f=stall_d=1` when D reads reg X, E is a valid load, and E.dest==X.
- **Branch operand stall:** when D is BEQ, `stall_f=stall_d=1` in either case:
  - E is valid, writes, and E.dest matches rs or rt;
  - M is a valid load and M.dest matches rs or rt.
- **Flush:** `flush_d=1` when D is J, or when D is BEQ with `branch_taken_d=1`. Flush is suppressed in any cycle where `stall_d` or `stall_all` is high.
- **Memory wait:** `stall_all=1` while M is a valid LW or SW and `mem_ready=0`. `stall_all` also forces `stall_f=1`. While `stall_all` is high, `stall_d` is 0 and `flush_d` is 0.
- **Forwarding** (EX operand A uses E.rs, operand B uses E.rt):
  - FWD_MEM when M is valid, writes, is not a load, and M.dest matches.
  - Otherwise FWD_WB when W is valid, writes, and W.dest matches.
  - Otherwise FWD_REG.
  - M has priority over W. An E bubble gives FWD_REG.
- **Counter:** `stall_cnt` increments when `stall_f=1` and saturates at all-ones.

## Timing
- Reset asserted:
  - all shadow entries become invalid and `stall_cnt` becomes 0;
  - consequently `stall_f`, `stall_d`, `flush_d` and `stall_all` are 0, and `fwd_a_e`/`fwd_b_e` are FWD_REG.
- Reset deassertion and mid-operation assertion behave the same way: state clears immediately, and the first edge after release loads E from decode.
- Stall, flush and forwarding outputs are combinational from `instr_d`, `valid_d`, `branch_taken_d`, `mem_ready` and the shadow registers, with zero latency.
- Shadow state and counter update on the rising edge.
- A load-use stall lasts exactly 1 cycle when no memory wait occurs. A branch stall lasts 1 or 2 cycles.
- When a memory wait and a load-use condition coincide, `stall_all` wins. The load-use stall re-evaluates after `mem_ready` rises.
- `valid_d=0` generates no stalls and no flushes.

## Structure
- Shared package `definitions` gains:
  - `FwdSel` enum: FWD_REG=0, FWD_MEM=1, FWD_WB=2;
  - `StageTag` struct for a shadow entry;
  - reuses `Register`, `Instruction` and the opcode/funct enums already in the package.
- Sub-module `reg_use`: a combinational decoder from Instruction to {rs_used, rt_used, dest, writes, is_load}. It is instantiated once for D; E, M and W store its output.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with a J in D → all outputs are 0 / FWD_REG and `stall_cnt`=0.
- **Load-use:** LW r4←(r9), then RTYPE ADD r3←r4+r1, with `mem_ready`=1 → exactly 1 cycle of `stall_f`/`stall_d`=1. On the next cycle `fwd_a_e`=FWD_WB, and `stall_cnt`=1.
- **ALU forwarding and priority:**
  - ADD r5←r1+r2, then ADD r6←r5+r5 → `fwd_a_e`=`fwd_b_e`=FWD_MEM.
  - ADD r5, ADD r5, then ADD r7←r5+r0 → `fwd_a_e`=FWD_MEM (M wins over W) and `fwd_b_e`=FWD_REG.
- **Branch:**
  - ADD r3←…, then BEQ r3,r0 → 1-cycle stall.
  - Then with `branch_taken_d`=1 → `flush_d`=1 for 1 cycle.
  - A J in D → `flush_d`=1.
- **Memory wait:** SW in M with `mem_ready`=0 for 3 cycles → `stall_all`=1 for 3 cycles, E and M hold, `flush_d`=0 throughout, and `stall_cnt` increases by 3.
- **Mid-operation reset and saturation:**
  - Assert reset during a load-use stall → outputs clear immediately.
  - With `CNT_W`=2 and 5 stall cycles → `stall_cnt` ends at 3.
